// File: rtl/rom_prog_ctrl_pkg.sv
// Shared definitions for the instruction-ROM programmer: frame header default,
// error codes and FSM state encodings.
package rom_prog_ctrl_pkg;

  localparam logic [7:0] HDR_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_BAD_LEN  = 2'd1,
    ERR_BAD_CSUM = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } err_code_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_e;

  // States in which a frame is open and the inter-byte timeout applies.
  function automatic logic in_frame(input state_e s);
    return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/rom_prog_ctrl_if.sv
// Byte-stream input, ROM write port and core control bundle of the programmer.
// master = the programmer, slave = the byte source / ROM / core side.
interface rom_prog_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic             byte_valid;
  logic [7:0]       byte_data;
  logic             byte_ready;
  logic             rom_wr_en;
  logic [WIDTH-1:0] rom_wr_addr;
  logic [WIDTH-1:0] rom_wr_data;
  logic             core_halt;
  logic             core_rst_req;
  logic             prog_done;
  logic             prog_err;
  logic [1:0]       err_code;

  modport master (
    input  byte_valid, byte_data,
    output byte_ready, rom_wr_en, rom_wr_addr, rom_wr_data,
    output core_halt, core_rst_req, prog_done, prog_err, err_code
  );

  modport slave (
    output byte_valid, byte_data,
    input  byte_ready, rom_wr_en, rom_wr_addr, rom_wr_data,
    input  core_halt, core_rst_req, prog_done, prog_err, err_code
  );
endinterface

// File: rtl/rom_prog_timer.sv
// Inter-byte idle counter: cleared on demand, counts while enabled and
// saturates at TIMEOUT-1, where expired_o is raised.
module rom_prog_timer #(
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int unsigned  CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && (count_q != LAST)) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = en_i && (count_q == LAST);

endmodule

// File: rtl/rom_prog_ctrl.sv
// In-system programmer for the instruction ROM: parses framed byte stream,
// packs little-endian words onto the ROM write port, halts/restarts the core.
module rom_prog_ctrl
  import rom_prog_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned AW      = 12,
  parameter int unsigned TIMEOUT = 1000000,
  parameter logic [7:0]  HDR     = HDR_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  rom_prog_ctrl_if.master bus
);
  // One extra counter bit so a full 2**AW-word image terminates without wrap.
  localparam int unsigned  CW      = AW + 1;
  localparam logic [16:0]  MAX_LEN = 17'(1 << AW);

  state_e          state_q, state_d;
  err_code_e       err_code_q, err_code_d;

  logic            byte_ready, prog_done, prog_err, core_rst_req;
  logic            accept, expired, timeout_hit;
  logic            timer_clear, timer_en, lane_we;
  logic            len_bad, last_word, csum_ok;
  logic [16:0]     len_full;

  logic [7:0]      len_lo_q, len_lo_d;
  logic [CW-1:0]   len_q, len_d;
  logic [CW-1:0]   word_cnt_q, word_cnt_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic [23:0]     pack_q, pack_d;
  logic [7:0]      csum_q, csum_d;
  logic            wr_en_q, wr_en_d;
  logic [WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0] wr_data_q, wr_data_d;
  logic            halt_q, halt_d;

  assign accept      = bus.byte_valid & byte_ready;
  assign len_full    = {1'b0, bus.byte_data, len_lo_q};
  assign len_bad     = (len_full == 17'd0) || (len_full > MAX_LEN);
  assign last_word   = ((word_cnt_q + CW'(1)) == len_q);
  assign csum_ok     = (bus.byte_data == csum_q);
  assign timeout_hit = in_frame(state_q) && !accept && expired;

  assign timer_clear = accept || (state_q == ST_IDLE);
  assign timer_en    = in_frame(state_q);

  rom_prog_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (timer_clear),
    .en_i      (timer_en),
    .expired_o (expired)
  );

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  // An accepted byte always takes priority over a timeout in the same cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept && (bus.byte_data == HDR)) state_d = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (accept)           state_d = ST_LEN_HI;
        else if (timeout_hit) state_d = ST_ERR;
      end
      ST_LEN_HI: begin
        if (accept)           state_d = len_bad ? ST_ERR : ST_DATA;
        else if (timeout_hit) state_d = ST_ERR;
      end
      ST_DATA: begin
        if (accept) begin
          if ((byte_cnt_q == 2'd3) && last_word) state_d = ST_CSUM;
        end else if (timeout_hit) begin
          state_d = ST_ERR;
        end
      end
      ST_CSUM: begin
        if (accept)           state_d = csum_ok ? ST_DONE : ST_ERR;
        else if (timeout_hit) state_d = ST_ERR;
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    byte_ready   = 1'b1;
    prog_done    = 1'b0;
    prog_err     = 1'b0;
    core_rst_req = 1'b0;
    unique case (state_q)
      ST_DONE: begin
        byte_ready   = 1'b0;
        prog_done    = 1'b1;
        core_rst_req = 1'b1;
      end
      ST_ERR: begin
        byte_ready = 1'b0;
        prog_err   = 1'b1;
      end
      default: ;
    endcase
  end

  // Packer lanes 0..2 hold the first three bytes; lane 3 goes straight to the ROM.
  assign lane_we = (state_q == ST_DATA) && accept;

  for (genvar gi = 0; gi < 3; gi++) begin : g_lane
    assign pack_d[8*gi +: 8] = (lane_we && (byte_cnt_q == 2'(gi))) ? bus.byte_data
                                                                   : pack_q[8*gi +: 8];
  end

  // ---------------- datapath next-state ----------------
  always_comb begin
    len_lo_d   = len_lo_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    csum_d     = csum_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    halt_d     = halt_q;
    err_code_d = err_code_q;

    if (timeout_hit) err_code_d = ERR_TIMEOUT;

    unique case (state_q)
      ST_IDLE: begin
        if (accept && (bus.byte_data == HDR)) halt_d = 1'b1;
      end
      ST_LEN_LO: begin
        if (accept) len_lo_d = bus.byte_data;
      end
      ST_LEN_HI: begin
        if (accept) begin
          if (len_bad) begin
            err_code_d = ERR_BAD_LEN;
          end else begin
            len_d      = len_full[CW-1:0];
            word_cnt_d = '0;
            byte_cnt_d = '0;
            csum_d     = '0;
          end
        end
      end
      ST_DATA: begin
        if (accept) begin
          csum_d     = csum_q + bus.byte_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            wr_en_d    = 1'b1;
            wr_addr_d  = WIDTH'({word_cnt_q, 2'b00});
            wr_data_d  = WIDTH'({bus.byte_data, pack_q});
            word_cnt_d = word_cnt_q + CW'(1);
          end
        end
      end
      ST_CSUM: begin
        if (accept) err_code_d = csum_ok ? ERR_NONE : ERR_BAD_CSUM;
      end
      ST_DONE: halt_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_lo_q   <= '0;
      len_q      <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      pack_q     <= '0;
      csum_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      halt_q     <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      len_lo_q   <= len_lo_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      pack_q     <= pack_d;
      csum_q     <= csum_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      halt_q     <= halt_d;
      err_code_q <= err_code_d;
    end
  end

  assign bus.byte_ready   = byte_ready;
  assign bus.rom_wr_en    = wr_en_q;
  assign bus.rom_wr_addr  = wr_addr_q;
  assign bus.rom_wr_data  = wr_data_q;
  assign bus.core_halt    = halt_q;
  assign bus.core_rst_req = core_rst_req;
  assign bus.prog_done    = prog_done;
  assign bus.prog_err     = prog_err;
  assign bus.err_code     = err_code_q;

endmodule
